branch_sched: RTL

BRANCH_SCHED -- requirements
Module: branch_sched

---
 rtl/isa_pkg.sv | 32 +++
 rtl/branch_sched_stats.sv | 21 ++
 rtl/branch_sched.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/isa_pkg.sv
// Shared ISA types plus the branch scheduler queue entry and FSM state.
package isa_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [2:0] {
      BR_EQ  = 3'd0,
      BR_NE  = 3'd1,
      BR_LT  = 3'd4,
      BR_GE  = 3'd5,
      BR_LTU = 3'd6,
      BR_GEU = 3'd7
   } branch_t;

   typedef enum logic [1:0] {RUN, WAIT, FLUSH} bsq_state_t;

   // Source tags live beside the queue because their width is a module parameter.
   typedef struct packed {
      logic       valid;
      logic       branch;
      branch_t    branch_type;
      logic [1:0] j_type;
      word_t      pc;
      word_t      imm;
      logic       pred;
      logic       rs1_rdy;
      logic       rs2_rdy;
      word_t      rs1_val;
      word_t      rs2_val;
   } bsq_entry_t;

endpackage

// File: rtl/branch_sched_stats.sv
// Free-running resolve/mispredict counters; cleared only by reset.
module branch_sched_stats (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        inc_resolved,
   input  logic        inc_miss,
   output logic [31:0] stat_resolved,
   output logic [31:0] stat_miss
);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stat_resolved <= '0;
         stat_miss     <= '0;
      end else begin
         if (inc_resolved) stat_resolved <= stat_resolved + 32'd1;
         if (inc_miss)     stat_miss     <= stat_miss + 32'd1;
      end
   end

endmodule

// File: rtl/branch_sched.sv
// In-order branch issue queue feeding a single branch FU; mispredict flushes younger ops.
// Optional counters under BRANCH_SCHED_STATS_EN.
module branch_sched
   import isa_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int REG_W = 5
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             disp_valid,
   output logic             disp_ready,
   input  logic             disp_branch,
   input  branch_t          disp_branch_type,
   input  logic [1:0]       disp_j_type,
   input  word_t            disp_pc,
   input  word_t            disp_imm,
   input  logic             disp_pred,
   input  logic [REG_W-1:0] disp_rs1,
   input  logic [REG_W-1:0] disp_rs2,
   input  logic             disp_rs1_rdy,
   input  logic             disp_rs2_rdy,
   input  word_t            disp_rs1_val,
   input  word_t            disp_rs2_val,
   input  logic             wb_valid,
   input  logic [REG_W-1:0] wb_reg,
   input  word_t            wb_data,
   output logic             fu_enable,
   output logic             fu_branch,
   output branch_t          fu_branch_type,
   output logic [1:0]       fu_j_type,
   output word_t            fu_reg_a,
   output word_t            fu_reg_b,
   output word_t            fu_current_pc,
   output word_t            fu_imm,
   output logic             fu_predicted_outcome,
   input  logic             fu_resolved,
   input  logic             fu_miss,
   input  word_t            fu_correct_pc,
   input  logic             ext_flush,
   output logic             flush_o,
   output word_t            redirect_pc,
   output logic             busy
`ifdef BRANCH_SCHED_STATS_EN
   ,
   output logic [31:0]      stat_resolved,
   output logic [31:0]      stat_miss
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   bsq_state_t       state, state_nx;
   bsq_entry_t       ent [DEPTH];
   logic [REG_W-1:0] tag1 [DEPTH];
   logic [REG_W-1:0] tag2 [DEPTH];
   logic [AW-1:0]    head, tail;
   logic [AW:0]      count;
   bsq_entry_t       head_ent, new_ent;
   logic             push, issue, pop, miss, clear;
   logic             wb_hit, wake1, wake2;

   assign disp_ready = (count < FULL) && (state != FLUSH);
   assign push       = disp_valid && disp_ready;
   assign head_ent   = ent[head];
   assign busy       = (count != '0) || (state == WAIT);
   // Register 0 is hardwired, so its broadcast never carries a real result.
   assign wb_hit     = wb_valid && (wb_reg != '0);
   assign wake1      = wb_hit && !disp_rs1_rdy && (disp_rs1 == wb_reg);
   assign wake2      = wb_hit && !disp_rs2_rdy && (disp_rs2 == wb_reg);
   assign clear      = miss || ext_flush;

   always_comb begin
      new_ent             = '0;
      new_ent.valid       = 1'b1;
      new_ent.branch      = disp_branch;
      new_ent.branch_type = disp_branch_type;
      new_ent.j_type      = disp_j_type;
      new_ent.pc          = disp_pc;
      new_ent.imm         = disp_imm;
      new_ent.pred        = disp_pred;
      new_ent.rs1_rdy     = disp_rs1_rdy || wake1;
      new_ent.rs2_rdy     = disp_rs2_rdy || wake2;
      new_ent.rs1_val     = wake1 ? wb_data : disp_rs1_val;
      new_ent.rs2_val     = wake2 ? wb_data : disp_rs2_val;
   end

   always_comb begin
      state_nx = state;
      issue    = 1'b0;
      pop      = 1'b0;
      miss     = 1'b0;
      case (state)
         RUN:
            if (head_ent.valid && head_ent.rs1_rdy && head_ent.rs2_rdy) begin
               issue    = 1'b1;
               state_nx = WAIT;
            end
         WAIT:
            if (fu_resolved) begin
               if (fu_miss) begin
                  miss     = 1'b1;
                  state_nx = FLUSH;
               end else begin
                  pop      = 1'b1;
                  state_nx = RUN;
               end
            end
         default: state_nx = RUN;
      endcase
      // External squash overrides everything, including a same-cycle mispredict.
      if (ext_flush) begin
         state_nx = RUN;
         issue    = 1'b0;
         pop      = 1'b0;
         miss     = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ent[i]  <= '0;
            tag1[i] <= '0;
            tag2[i] <= '0;
         end
      end else if (clear) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) ent[i].valid <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (ent[i].valid && wb_hit && !ent[i].rs1_rdy && (tag1[i] == wb_reg)) begin
               ent[i].rs1_rdy <= 1'b1;
               ent[i].rs1_val <= wb_data;
            end
            if (ent[i].valid && wb_hit && !ent[i].rs2_rdy && (tag2[i] == wb_reg)) begin
               ent[i].rs2_rdy <= 1'b1;
               ent[i].rs2_val <= wb_data;
            end
         end
         if (push) begin
            ent[tail]  <= new_ent;
            tag1[tail] <= disp_rs1;
            tag2[tail] <= disp_rs2;
            tail       <= tail + 1'b1;
         end
         if (pop) begin
            ent[head].valid <= 1'b0;
            head            <= head + 1'b1;
         end
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state                <= RUN;
         fu_enable            <= 1'b0;
         fu_branch            <= 1'b0;
         fu_branch_type       <= BR_EQ;
         fu_j_type            <= '0;
         fu_reg_a             <= '0;
         fu_reg_b             <= '0;
         fu_current_pc        <= '0;
         fu_imm               <= '0;
         fu_predicted_outcome <= 1'b0;
         flush_o              <= 1'b0;
         redirect_pc          <= '0;
      end else begin
         state   <= state_nx;
         flush_o <= miss;
         if (miss) redirect_pc <= fu_correct_pc;
         if (issue) begin
            fu_enable            <= 1'b1;
            fu_branch            <= head_ent.branch;
            fu_branch_type       <= head_ent.branch_type;
            fu_j_type            <= head_ent.j_type;
            fu_reg_a             <= head_ent.rs1_val;
            fu_reg_b             <= head_ent.rs2_val;
            fu_current_pc        <= head_ent.pc;
            fu_imm               <= head_ent.imm;
            fu_predicted_outcome <= head_ent.pred;
         end else if (pop || miss || ext_flush) begin
            fu_enable <= 1'b0;
         end
      end
   end

`ifdef BRANCH_SCHED_STATS_EN
   branch_sched_stats u_stats (
      .CLK           (CLK),
      .nRST          (nRST),
      .inc_resolved  (pop),
      .inc_miss      (miss),
      .stat_resolved (stat_resolved),
      .stat_miss     (stat_miss)
   );
`endif

endmodule
